// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM8 burst reader: word width and FSM encodings.
package ram_burst_reader_pkg;

    localparam int unsigned WORD = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/ram_burst_reader.sv
// Read-side burst sequencer for a combinational-read word RAM.
// Walks base, base+1, ... (mod 2^AW) for count words and streams each word
// out on a valid/ready interface; never writes the memory.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic [AW-1:0]    mem_address,
    output logic             mem_load,
    input  logic [WIDTH-1:0] mem_out,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             last,
    output logic             done
);

    localparam logic [AW-1:0] ADDR_STEP = AW'(1);
    localparam logic [AW:0]   REM_ONE   = (AW + 1)'(1);

    logic [1:0]    state;
    logic [AW-1:0] addr;
    logic [AW:0]   rem;
    logic          slot_free;

    // The output register may accept a new word when empty or being drained now.
    always_comb begin
        slot_free = !data_valid || data_ready;
    end

    // The address register drives the RAM directly, so the read data seen
    // in READ always belongs to the word about to be captured.
    always_comb begin
        mem_address = addr;
        mem_load    = 1'b0;
    end

    // Burst FSM, address/remaining counters and the registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            rem        <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr  <= base;
                            rem   <= count;
                            busy  <= 1'b1;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (slot_free) begin
                        data_out   <= mem_out;
                        data_valid <= 1'b1;
                        last       <= (rem == REM_ONE);
                        addr       <= addr + ADDR_STEP;
                        rem        <= rem - REM_ONE;
                        if (rem == REM_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (data_valid && data_ready) begin
                        data_valid <= 1'b0;
                        last       <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader with a preloaded 8-word RAM.
module tb_ram_burst_reader;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  base = '0;
    logic [3:0]  count = '0;
    logic        busy;
    logic [2:0]  mem_address;
    logic        mem_load;
    logic [15:0] mem_out;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        last;
    logic        done;

    logic [15:0] ram [0:7];
    beat_t       q[$];
    int          exp_done = 0;
    int          beats = 0;
    int          checks = 0;
    int          failures = 0;
    int          rmode = 0;     // 0 ready high, 1 toggle, 2 random, 3 low
    logic        load_seen = 1'b0;

    ram_burst_reader #(.WIDTH(16), .AW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .busy(busy), .mem_address(mem_address), .mem_load(mem_load),
        .mem_out(mem_out), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    assign mem_out = ram[mem_address];

    initial begin
        for (int k = 0; k < 8; k++) ram[k] = 16'h00A0 + 16'(k);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Consumer ready pattern, changed just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: data_ready = 1'b1;
            1: data_ready = ~data_ready;
            2: data_ready = 1'($urandom_range(0, 1));
            default: data_ready = 1'b0;
        endcase
    end

    // Monitor: pops expected beats on handshake, checks stall stability and done pulses.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        beat_t       e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_load) load_seen = 1'b1;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(data_valid), 32'd1);
                    chk("stall_data", 32'(data_out), 32'(prev_data));
                    chk("stall_last", 32'(last), 32'(prev_last));
                end
                if (data_valid && data_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", 32'(data_out), 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("beat_data", 32'(data_out), 32'(e.d));
                        chk("beat_last", 32'(last), 32'(e.l));
                    end
                    beats++;
                end
                if (done) begin
                    chk("done_expected", 32'(exp_done > 0), 32'd1);
                    if (exp_done > 0) exp_done--;
                end
                prev_stall = data_valid && !data_ready;
                prev_data  = data_out;
                prev_last  = last;
            end
        end
    end

    // Reference: burst of c words from base b is RAM[(b+i) mod 8], last on the final one.
    task automatic push_burst(input int b, input int c);
        beat_t e;
        for (int i = 0; i < c; i++) begin
            e.d = 16'h00A0 + 16'((b + i) % 8);
            e.l = (i == c - 1);
            q.push_back(e);
        end
        exp_done++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || exp_done != 0 || busy) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_complete"}, 32'(q.size() == 0 && exp_done == 0 && !busy), 32'd1);
        q.delete();
        exp_done = 0;
    endtask

    task automatic run_burst(input string name, input int b, input int c, input int mode);
        rmode = mode;
        @(posedge clk);
        #1;
        base  = 3'(b);
        count = 4'(c);
        start = 1'b1;
        push_burst(b, c);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        if (c == 0) begin
            chk({name, "_empty_done"}, 32'(done), 32'd1);
            chk({name, "_empty_busy"}, 32'(busy), 32'd0);
        end else begin
            chk({name, "_first_addr"}, 32'(mem_address), 32'(b));
            chk({name, "_busy"}, 32'(busy), 32'd1);
        end
        #1;
        wait_idle(name);
        @(negedge clk);
        chk({name, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        int b0;
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);

        run_burst("full", 0, 8, 0);
        run_burst("wrap", 6, 4, 0);
        run_burst("bp", 2, 3, 1);
        run_burst("empty", 4, 0, 0);
        run_burst("over", 5, 11, 2);

        // Reset after three beats of an eight-word burst.
        rmode = 0;
        @(posedge clk);
        #1;
        base = 3'd0; count = 4'd8; start = 1'b1;
        push_burst(0, 8);
        b0 = beats;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (beats - b0 < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_three_beats", 32'(beats - b0), 32'd3);
        rmode = 3;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_done = 0;
        @(negedge clk);
        chk("abort_valid", 32'(data_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(mem_address), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", 32'(data_valid | done), 32'd0);
        end
        run_burst("single", 5, 1, 1);

        // Start re-asserted while busy must be ignored.
        rmode = 1;
        @(posedge clk);
        #1;
        base = 3'd0; count = 4'd8; start = 1'b1;
        push_burst(0, 8);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            base = 3'd3; count = 4'd5; start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("restart");

        for (int t = 0; t < 25; t++) begin
            run_burst("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 2)));
        end

        chk("mem_load_never", 32'(load_seen), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
